lane_scroller: RTL

LANE_SCROLLER -- requirements
Module: lane_scroller

---
 rtl/scroll_pkg.sv | 8 +
 rtl/scroll_tick.sv | 21 ++
 rtl/lane_scroller.sv | 70 +++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// scroll_pkg: shared defaults and lane direction encoding for lane_scroller.
package scroll_pkg;
    localparam int SCREEN_W_DEF = 640;
    localparam int TICK_DIV_DEF = 250000;
    localparam int POS_W_DEF    = 10;
    localparam int STEP_W_DEF   = 4;
    typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_e;
endpackage

// File: rtl/scroll_tick.sv
// scroll_tick: prescaler that flags the update edge once every TICK_DIV running cycles.
module scroll_tick
    import scroll_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick_en
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] ctr_d, ctr_q;
    assign tick_en = run && ctr_q == LAST;
    always_comb ctr_d = !run ? ctr_q : tick_en ? '0 : ctr_q + 1'b1;
    always_ff @(posedge clk) begin
        if (reset) ctr_q <= '0;
        else       ctr_q <= ctr_d;
    end
endmodule

// File: rtl/lane_scroller.sv
// lane_scroller: independent wrapping lane positions stepped on a prescaled tick.
// Defining LANE_SCROLLER_BOOST_EN adds a boost input that doubles every lane step.
module lane_scroller
    import scroll_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int POS_W     = POS_W_DEF,
    parameter int SCREEN_W  = SCREEN_W_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int STEP_W    = STEP_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
`ifdef LANE_SCROLLER_BOOST_EN
    input  logic                          boost,
`endif
    input  logic [NUM_LANES-1:0]          lane_dir,
    input  logic [NUM_LANES*STEP_W-1:0]   lane_step,
    output logic [NUM_LANES*POS_W-1:0]    lane_pos,
    output logic                          tick,
    output logic [NUM_LANES-1:0]          wrap
);
    localparam int PW = POS_W + 1;
    localparam logic [PW-1:0] SW = PW'(SCREEN_W);
    logic                       tick_en, tick_d, tick_q;
    logic [NUM_LANES*POS_W-1:0] pos_d, pos_q;
    logic [NUM_LANES-1:0]       wrap_d, wrap_q;
    scroll_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .tick_en (tick_en)
    );
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [STEP_W:0] step;
        logic [PW-1:0]   pos, stp;
        logic [POS_W-1:0] nxt;
        logic            dec, wrp;
`ifdef LANE_SCROLLER_BOOST_EN
        assign step = boost ? {lane_step[i*STEP_W +: STEP_W], 1'b0} : {1'b0, lane_step[i*STEP_W +: STEP_W]};
`else
        assign step = {1'b0, lane_step[i*STEP_W +: STEP_W]};
`endif
        assign stp = PW'(step);
        assign pos = {1'b0, pos_q[i*POS_W +: POS_W]};
        assign dec = dir_e'(lane_dir[i]) == DIR_DEC;
        // Step is always smaller than the screen, so one correction by SCREEN_W suffices.
        assign wrp = dec ? pos < stp : pos + stp >= SW;
        assign nxt = POS_W'(dec ? (wrp ? pos + SW - stp : pos - stp)
                                : (wrp ? pos + stp - SW : pos + stp));
        assign pos_d[i*POS_W +: POS_W] = tick_en ? nxt : pos_q[i*POS_W +: POS_W];
        assign wrap_d[i] = tick_en & wrp;
    end
    assign tick_d = tick_en;
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q  <= '0;
            wrap_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
            tick_q <= tick_d;
        end
    end
    assign lane_pos = pos_q;
    assign wrap     = wrap_q;
    assign tick     = tick_q;
endmodule
